// File: rtl/comp_seq_ctrl.sv
// Sequential magnitude comparator: walks two WIDTH-bit operands 2 bits per cycle, MSB slice
// first, through a 2-bit e/l/g comparator slice and reports a one-hot e/l/g verdict.
module comp_seq_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             e,
  output logic             l,
  output logic             g
);

  localparam int unsigned S  = WIDTH / 2;
  localparam int unsigned KW = (S > 1) ? $clog2(S) : 1;
  localparam logic [KW-1:0] KMax = KW'(S - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [KW-1:0]    k_q;
  logic             seen_q, held_l_q, held_g_q;

  logic [1:0] slice_a, slice_b;
  logic       sl_e, sl_l, sl_g;

  // Slice mux with constant indices keeps the select free of variable part-selects.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int unsigned i = 0; i < S; i++) begin
      if (k_q == KW'(i)) begin
        slice_a = a_q[2*i +: 2];
        slice_b = b_q[2*i +: 2];
      end
    end
  end

  // Shared 2-bit comparator slice.
  always_comb begin
    sl_e = (slice_a == slice_b);
    sl_l = (slice_a <  slice_b);
    sl_g = (slice_a >  slice_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      busy     <= 1'b0;
      done     <= 1'b0;
      e        <= 1'b0;
      l        <= 1'b0;
      g        <= 1'b0;
      k_q      <= KMax;
      a_q      <= '0;
      b_q      <= '0;
      seen_q   <= 1'b0;
      held_l_q <= 1'b0;
      held_g_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            k_q      <= KMax;
            busy     <= 1'b1;
            e        <= 1'b0;
            l        <= 1'b0;
            g        <= 1'b0;
            seen_q   <= 1'b0;
            held_l_q <= 1'b0;
            held_g_q <= 1'b0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          if (!sl_e && EARLY_EXIT) begin
            l       <= sl_l;
            g       <= sl_g;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            // Without early exit only the most significant unequal slice decides.
            if (!sl_e && !seen_q) begin
              seen_q   <= 1'b1;
              held_l_q <= sl_l;
              held_g_q <= sl_g;
            end
            if (k_q == '0) begin
              if (seen_q) begin
                e <= 1'b0;
                l <= held_l_q;
                g <= held_g_q;
              end else begin
                e <= sl_e;
                l <= sl_l;
                g <= sl_g;
              end
              done    <= 1'b1;
              busy    <= 1'b0;
              state_q <= StIdle;
            end else begin
              k_q <= k_q - 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Bench for comp_seq_ctrl: one early-exit and one full-scan instance share stimulus and are
// checked every cycle against a latency/arithmetic reference model, plus vector tables.
module tb_comp_seq_ctrl;

  localparam int W = 8;
  localparam int S = W / 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   busy_w, done_w, e_w, l_w, g_w;

  int n_vec = 0;
  int n_err = 0;

  comp_seq_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy_w[0]), .done(done_w[0]), .e(e_w[0]), .l(l_w[0]), .g(g_w[0])
  );

  comp_seq_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy_w[1]), .done(done_w[1]), .e(e_w[1]), .l(l_w[1]), .g(g_w[1])
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ref_elg(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x == y) return 3'b100;
    if (x < y) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y, input bit early);
    if (!early) return S;
    for (int j = 0; j < S; j++) begin
      if (((x >> (2 * (S - 1 - j))) & 3) != ((y >> (2 * (S - 1 - j))) & 3)) return j + 1;
    end
    return S;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: request accepted when idle, result appears after the computed latency.
  bit       m_busy [2];
  bit       m_done [2];
  int       m_left [2];
  logic [2:0] m_out  [2];
  logic [2:0] m_pend [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_done[i] = 0; m_left[i] = 0; m_out[i] = 3'b000; m_pend[i] = 3'b000;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          m_busy[i] = 0; m_done[i] = 0; m_out[i] = 3'b000;
        end else if (m_busy[i]) begin
          m_left[i]--;
          m_done[i] = (m_left[i] == 0);
          if (m_done[i]) begin
            m_busy[i] = 0;
            m_out[i]  = m_pend[i];
          end
        end else begin
          m_done[i] = 0;
          if (start) begin
            m_busy[i] = 1;
            m_left[i] = ref_lat(a, b, i == 0);
            m_pend[i] = ref_elg(a, b);
            m_out[i]  = 3'b000;
          end
        end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        check($sformatf("cycle[%0d] busy/done/elg", i),
              {27'd0, busy_w[i], done_w[i], e_w[i], l_w[i], g_w[i]},
              {27'd0, m_busy[i], m_done[i], m_out[i]});
      end
    end
  end

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [2:0]   elg;
    int           lat;
  } vec_t;

  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb);
    @(negedge clk);
    start = 1'b1; a = xa; b = xb;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycles from the accepting edge until done on instance idx; 0 means it never came.
  task automatic measure(input int idx, output int cycles);
    cycles = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (done_w[idx]) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!busy_w[0] && !busy_w[1]) begin
        ok = 1;
        break;
      end
    end
    check("wait_idle bound", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    vec_t tbl [8];
    int   lat;

    tbl[0] = '{8'hA5, 8'hA5, 3'b100, 4};
    tbl[1] = '{8'h80, 8'h7F, 3'b001, 1};
    tbl[2] = '{8'h12, 8'h13, 3'b010, 4};
    tbl[3] = '{8'hFF, 8'h00, 3'b001, 1};
    tbl[4] = '{8'h30, 8'h20, 3'b001, 2};
    tbl[5] = '{8'h0C, 8'h08, 3'b001, 3};
    tbl[6] = '{8'h00, 8'h00, 3'b100, 4};
    tbl[7] = '{8'h7F, 8'h80, 3'b010, 1};

    #12;
    check("reset outputs ee", {27'd0, busy_w[0], done_w[0], e_w[0], l_w[0], g_w[0]}, 32'd0);
    check("reset outputs full", {27'd0, busy_w[1], done_w[1], e_w[1], l_w[1], g_w[1]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      issue(tbl[i].va, tbl[i].vb);
      measure(0, lat);
      check($sformatf("tbl%0d latency", i), lat, tbl[i].lat);
      check($sformatf("tbl%0d elg ee", i), {29'd0, e_w[0], l_w[0], g_w[0]}, {29'd0, tbl[i].elg});
      wait_idle();
      check($sformatf("tbl%0d elg full", i), {29'd0, e_w[1], l_w[1], g_w[1]},
            {29'd0, tbl[i].elg});
    end

    // Second start while busy is ignored.
    @(negedge clk);
    start = 1'b1; a = 8'h40; b = 8'h00;
    @(negedge clk);
    a = 8'h00; b = 8'hFF;
    @(posedge clk);
    #1;
    check("ignore done", {31'd0, done_w[0]}, 32'd1);
    check("ignore g", {29'd0, e_w[0], l_w[0], g_w[0]}, 32'b001);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("ignore full g", {29'd0, e_w[1], l_w[1], g_w[1]}, 32'b001);

    // Asynchronous reset aborts a compare mid-run.
    issue(8'h12, 8'h13);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort ee", {27'd0, busy_w[0], done_w[0], e_w[0], l_w[0], g_w[0]}, 32'd0);
    check("abort full", {27'd0, busy_w[1], done_w[1], e_w[1], l_w[1], g_w[1]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'h00, 8'h00);
    measure(0, lat);
    check("post-reset latency", lat, 4);
    check("post-reset e", {31'd0, e_w[0]}, 32'd1);
    wait_idle();

    // Full-scan: restart on the done cycle with no idle gap.
    issue(8'h80, 8'h7F);
    measure(1, lat);
    check("full latency", lat, 4);
    check("full g", {29'd0, e_w[1], l_w[1], g_w[1]}, 32'b001);
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h02;
    @(negedge clk);
    start = 1'b0;
    measure(1, lat);
    check("b2b latency", lat, 4);
    check("b2b l", {29'd0, e_w[1], l_w[1], g_w[1]}, 32'b010);
    wait_idle();

    // Random traffic; biased so operands often share upper slices.
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) != 0);
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ W'(1 << $urandom_range(0, W - 1));
        2: b = a ^ W'($urandom_range(0, 3));
        default: b = W'($urandom);
      endcase
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
